gpr_write_arbiter: RTL and testbench

Write-port arbiter and merge controller for the eight-entry general purpose register file. It accepts write requests from up to `REQUESTERS` sources (ALU writeback, load unit, stack unit, ...) through valid/ready handshakes and grants one per cycle in round-robin order. It converts 8/16/32-bit architectural writes (AL..DH, AX..SP, EAX..ESP) into full 32-bit read-modify-write updates on the register file's single write port.

---
 rtl/gpr_write_arbiter_if.sv | 31 +++
 rtl/gpr_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_gpr_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_write_arbiter_if.sv
// Bundle of request handshakes and register-file write/merge signals for
// gpr_write_arbiter. The slave modport is the arbiter; the master modport is
// the environment (requesting units plus the register file).
interface gpr_write_arbiter_if #(
  parameter int REQUESTERS = 3
);
  logic [REQUESTERS-1:0]    req_valid;
  logic [REQUESTERS-1:0]    req_ready;
  logic [3*REQUESTERS-1:0]  req_index;
  logic [2*REQUESTERS-1:0]  req_size;
  logic [32*REQUESTERS-1:0] req_data;
  logic [2:0]               rf_read_index;
  logic [31:0]              rf_read_data;
  logic                     rf_write_enable;
  logic [2:0]               rf_write_index;
  logic [31:0]              rf_write_data;
  logic                     size_error;
  logic                     busy;

  modport master (
    output req_valid, req_index, req_size, req_data, rf_read_data,
    input  req_ready, rf_read_index, rf_write_enable, rf_write_index,
           rf_write_data, size_error, busy
  );

  modport slave (
    input  req_valid, req_index, req_size, req_data, rf_read_data,
    output req_ready, rf_read_index, rf_write_enable, rf_write_index,
           rf_write_data, size_error, busy
  );
endinterface

// File: rtl/gpr_write_arbiter.sv
// Round-robin write-port arbiter and sub-register merge for the 8-entry GPR
// file. Three stages: arbitration (A, combinational), merge (M), write (W).
// Optional build macro GPR_ARB_BYPASS_EN: forward W's data into the M merge
// on a same-register hazard instead of stalling M for one cycle.
module gpr_write_arbiter #(
  parameter int REQUESTERS = 3
) (
  input  logic              clock,
  input  logic              reset,
  gpr_write_arbiter_if.slave bus
);

  localparam logic [1:0] SIZE_8   = 2'b00;
  localparam logic [1:0] SIZE_16  = 2'b01;
  localparam logic [1:0] SIZE_32  = 2'b10;
  localparam logic [2:0] LAST_RST = 3'(REQUESTERS - 1);

  // Architectural state
  logic [2:0]  last_q, last_d;
  logic        m_valid_q, m_valid_d;
  logic [2:0]  m_index_q, m_index_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [31:0] m_data_q, m_data_d;
  logic        w_valid_q, w_valid_d;
  logic [2:0]  w_index_q, w_index_d;
  logic [31:0] w_data_q, w_data_d;
  logic        size_error_q, size_error_d;

  // Combinational helpers
  logic                  grant_found_s;
  logic [2:0]            grant_idx_s;
  logic [2:0]            sel_index_s;
  logic [1:0]            sel_size_s;
  logic [31:0]           sel_data_s;
  logic [2:0]            m_phys_s;
  logic                  same_reg_s;
  logic                  m_stall_s;
  logic                  m_advance_s;
  logic                  accept_s;
  logic [31:0]           old_s;
  logic [31:0]           merged_s;
  logic [REQUESTERS-1:0] ready_s;

  // Round-robin search: first valid source starting after the last winner.
  always_comb begin
    logic [7:0] valid8_v;
    logic [3:0] cand_v;
    logic       hit_v;
    valid8_v      = 8'(bus.req_valid);
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      cand_v = {1'b0, last_q} + 4'(k);
      cand_v = (cand_v >= 4'(REQUESTERS)) ? (cand_v - 4'(REQUESTERS)) : cand_v;
      hit_v  = ~grant_found_s & valid8_v[cand_v[2:0]];
      grant_idx_s   = hit_v ? cand_v[2:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_v;
    end
  end

  // Select the granted source's payload.
  always_comb begin
    sel_index_s = 3'd0;
    sel_size_s  = 2'b00;
    sel_data_s  = 32'd0;
    for (int s = 0; s < REQUESTERS; s++) begin
      sel_index_s = (3'(s) == grant_idx_s) ? bus.req_index[3*s +: 3]  : sel_index_s;
      sel_size_s  = (3'(s) == grant_idx_s) ? bus.req_size[2*s +: 2]   : sel_size_s;
      sel_data_s  = (3'(s) == grant_idx_s) ? bus.req_data[32*s +: 32] : sel_data_s;
    end
  end

  // M-stage physical index, hazard detection and sub-register merge.
  always_comb begin
    m_phys_s   = ((m_size_q == SIZE_8) && m_index_q[2]) ? {1'b0, m_index_q[1:0]} : m_index_q;
    same_reg_s = m_valid_q & w_valid_q & (w_index_q == m_phys_s);
`ifdef GPR_ARB_BYPASS_EN
    old_s      = same_reg_s ? w_data_q : bus.rf_read_data;
    m_stall_s  = 1'b0;
`else
    old_s      = bus.rf_read_data;
    m_stall_s  = same_reg_s;
`endif
    m_advance_s = m_valid_q & ~m_stall_s;
    case (m_size_q)
      SIZE_32: merged_s = m_data_q;
      SIZE_16: merged_s = {old_s[31:16], m_data_q[15:0]};
      SIZE_8:  merged_s = m_index_q[2] ? {old_s[31:16], m_data_q[7:0], old_s[7:0]}
                                       : {old_s[31:8], m_data_q[7:0]};
      default: merged_s = old_s;
    endcase
  end

  // Grant only while out of reset and M can take a new request.
  always_comb begin
    accept_s = reset & grant_found_s & (~m_valid_q | m_advance_s);
    for (int s = 0; s < REQUESTERS; s++) begin
      ready_s[s] = accept_s & (grant_idx_s == 3'(s));
    end
  end

  // Next-state for pointer and pipeline stages; reserved size never loads W.
  always_comb begin
    last_d = accept_s ? grant_idx_s : last_q;
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_index_d = sel_index_s;
      m_size_d  = sel_size_s;
      m_data_d  = sel_data_s;
    end else begin
      m_valid_d = m_valid_q & m_stall_s;
      m_index_d = m_index_q;
      m_size_d  = m_size_q;
      m_data_d  = m_data_q;
    end
    w_valid_d    = m_advance_s & (m_size_q != 2'b11);
    w_index_d    = w_valid_d ? m_phys_s : w_index_q;
    w_data_d     = w_valid_d ? merged_s : w_data_q;
    size_error_d = m_advance_s & (m_size_q == 2'b11);
  end

  // State registers; reset discards any in-flight request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q       <= LAST_RST;
      m_valid_q    <= 1'b0;
      m_index_q    <= 3'd0;
      m_size_q     <= 2'b00;
      m_data_q     <= 32'd0;
      w_valid_q    <= 1'b0;
      w_index_q    <= 3'd0;
      w_data_q     <= 32'd0;
      size_error_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      m_valid_q    <= m_valid_d;
      m_index_q    <= m_index_d;
      m_size_q     <= m_size_d;
      m_data_q     <= m_data_d;
      w_valid_q    <= w_valid_d;
      w_index_q    <= w_index_d;
      w_data_q     <= w_data_d;
      size_error_q <= size_error_d;
    end
  end

  assign bus.req_ready       = ready_s;
  assign bus.rf_read_index   = m_valid_q ? m_phys_s : 3'd0;
  assign bus.rf_write_enable = w_valid_q;
  assign bus.rf_write_index  = w_index_q;
  assign bus.rf_write_data   = w_data_q;
  assign bus.size_error      = size_error_q;
  assign bus.busy            = m_valid_q | w_valid_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench for gpr_write_arbiter: vector table plus hand-written
// sequences; expected writes go to a scoreboard queue and are checked when
// the DUT strobes the register file.
module tb_gpr_write_arbiter;
  localparam int R = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  int   err_cyc = -1;
  logic [31:0] rf [8];

  typedef struct { logic [2:0] idx; logic [31:0] data; int cyc; } exp_t;
  exp_t sbq[$];

  typedef struct {
    int src; logic [2:0] idx; logic [1:0] sz; logic [31:0] d;
    logic [2:0] eidx; logic [31:0] edata;
  } vec_t;
  vec_t tbl[9];

  gpr_write_arbiter_if #(.REQUESTERS(R)) bus();
  gpr_write_arbiter #(.REQUESTERS(R)) dut (.clock(clk), .reset(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model: combinational read, write on the clock edge.
  assign bus.rf_read_data = rf[bus.rf_read_index];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= 32'd0;
    end else if (bus.rf_write_enable) begin
      rf[bus.rf_write_index] <= bus.rf_write_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard check at each write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rf_write_enable) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got write idx %0d data %h, expected no write",
                   bus.rf_write_index, bus.rf_write_data);
        end else begin
          e = sbq.pop_front();
          chk("wr_index", 32'(bus.rf_write_index), 32'(e.idx));
          chk("wr_data", bus.rf_write_data, e.data);
          if (e.cyc >= 0) chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (bus.size_error) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
    end
  end

  task automatic push_exp(input logic [2:0] idx, input logic [31:0] d, input int c);
    exp_t e;
    e.idx = idx; e.data = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic drive(input int s, input logic [2:0] idx, input logic [1:0] sz, input logic [31:0] d);
    bus.req_index[3*s +: 3]  = idx;
    bus.req_size[2*s +: 2]   = sz;
    bus.req_data[32*s +: 32] = d;
    bus.req_valid[s]         = 1'b1;
  endtask

  // Wait (bounded) for ready on source s, then pass the accepting edge.
  task automatic accept(input int s, output int acc);
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready[s]) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (acc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: source %0d got no ready, expected ready within 20 cycles", s);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((sbq.size() != 0 || bus.busy) && i < 30) begin
      @(negedge clk);
      #2;
      i++;
    end
    chk("drain_pending", 32'(sbq.size()) | 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc, acc2, base, g;
    bus.req_valid = '0;
    bus.req_index = '0;
    bus.req_size  = '0;
    bus.req_data  = '0;

    tbl[0] = '{0, 3'd0, 2'b10, 32'h12345678, 3'd0, 32'h12345678};
    tbl[1] = '{1, 3'd4, 2'b00, 32'h000000AB, 3'd0, 32'h1234AB78};
    tbl[2] = '{2, 3'd0, 2'b01, 32'h0000CDEF, 3'd0, 32'h1234CDEF};
    tbl[3] = '{0, 3'd7, 2'b00, 32'hFFFFFF5A, 3'd3, 32'h00005A00};
    tbl[4] = '{1, 3'd3, 2'b00, 32'h00000077, 3'd3, 32'h00005A77};
    tbl[5] = '{2, 3'd6, 2'b01, 32'hAAAA5555, 3'd6, 32'h00005555};
    tbl[6] = '{0, 3'd6, 2'b10, 32'hDEADBEEF, 3'd6, 32'hDEADBEEF};
    tbl[7] = '{1, 3'd6, 2'b00, 32'h0000003C, 3'd2, 32'h00003C00};
    tbl[8] = '{2, 3'd6, 2'b01, 32'hFFFF1234, 3'd6, 32'hDEAD1234};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_we", 32'(bus.rf_write_enable), 32'd0);
    chk("rst_widx", 32'(bus.rf_write_index), 32'd0);
    chk("rst_wdata", bus.rf_write_data, 32'd0);
    chk("rst_serr", 32'(bus.size_error), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ridx", 32'(bus.rf_read_index), 32'd0);
    rst_n = 1'b1;

    // Table of single writes, each drained before the next
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].src, tbl[i].idx, tbl[i].sz, tbl[i].d);
      #1;
      accept(tbl[i].src, acc);
      bus.req_valid[tbl[i].src] = 1'b0;
      if (acc >= 0) push_exp(tbl[i].eidx, tbl[i].edata, acc + 1);
      drain();
    end

    // Round robin with all sources requesting continuously
    do_reset();
    @(negedge clk);
    for (int s = 0; s < R; s++) drive(s, 3'(s), 2'b10, 32'hC0DE0000 + 32'(s));
    g = 0;
    for (int t = 0; t < 20 && g < 9; t++) begin
      #1;
      if (bus.req_ready != '0) begin
        chk($sformatf("rr_grant%0d", g), 32'(bus.req_ready), 32'd1 << (g % 3));
        push_exp(3'(g % 3), 32'hC0DE0000 + 32'(g % 3), cyc + 2);
        g++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    chk("rr_grant_total", 32'(g), 32'd9);
    drain();

    // Back-to-back AL then AH on the same register
    do_reset();
    @(negedge clk);
    drive(0, 3'd0, 2'b00, 32'h00000011);
    #1;
    accept(0, acc);
    push_exp(3'd0, 32'h00000011, acc + 1);
    drive(0, 3'd4, 2'b00, 32'h00000022);
    #1;
    accept(0, acc2);
`ifdef GPR_ARB_BYPASS_EN
    push_exp(3'd0, 32'h00002211, acc2 + 1);
`else
    push_exp(3'd0, 32'h00002211, acc2 + 2);
`endif
    chk("b2b_accept_gap", 32'(acc2 - acc), 32'd1);
    drive(0, 3'd1, 2'b00, 32'h00000033);
    #1;
`ifdef GPR_ARB_BYPASS_EN
    chk("b2b_ready_no_stall", 32'(bus.req_ready), 32'd1);
`else
    chk("b2b_ready_stall", 32'(bus.req_ready), 32'd0);
`endif
    accept(0, acc);
    bus.req_valid = '0;
    push_exp(3'd1, 32'h00000033, -1);
    drain();
    chk("b2b_final_eax", rf[0], 32'h00002211);

    // Reserved size: accepted, no write, one size_error pulse
    base = err_cnt;
    @(negedge clk);
    drive(1, 3'd2, 2'b11, 32'hFFFFFFFF);
    #1;
    accept(1, acc);
    bus.req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("rsv_err_count", 32'(err_cnt - base), 32'd1);
    chk("rsv_err_cycle", 32'(err_cyc), 32'(acc + 1));
    chk("rsv_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    drive(1, 3'd2, 2'b10, 32'h600DCAFE);
    #1;
    accept(1, acc);
    bus.req_valid[1] = 1'b0;
    push_exp(3'd2, 32'h600DCAFE, acc + 1);
    drain();

    // Reset while M and W are both full
    @(negedge clk);
    drive(0, 3'd5, 2'b10, 32'h00000001);
    #1;
    accept(0, acc);
    drive(0, 3'd6, 2'b10, 32'h00000002);
    #1;
    accept(0, acc);
    bus.req_valid[0] = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_we", 32'(bus.rf_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.rf_write_enable), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_widx", 32'(bus.rf_write_index), 32'd0);
    chk("mid_rst_wdata", bus.rf_write_data, 32'd0);
    chk("mid_rst_ridx", 32'(bus.rf_read_index), 32'd0);
    drive(0, 3'd1, 2'b10, 32'h5A5A5A5A);
    drive(1, 3'd3, 2'b10, 32'h11111111);
    drive(2, 3'd7, 2'b10, 32'h22222222);
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("mid_rst_we_later", 32'(bus.rf_write_enable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_first_grant", 32'(bus.req_ready), 32'd1);
    accept(0, acc);
    bus.req_valid = '0;
    push_exp(3'd1, 32'h5A5A5A5A, acc + 1);
    drain();
    chk("post_rst_eax_clear", rf[0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
